// File: rtl/taxi_axis_gmii_rx.sv
// taxi_axis_gmii_rx: GMII/MII receive framer.
// Strips the preamble and SFD, checks the CRC-32 and emits each frame as an
// AXI4-Stream packet. tuser[0] is set on the tlast beat when the frame is bad.
// Optional feature macro: TAXI_AXIS_GMII_RX_PTP_TS_EN adds the ptp_ts input.
// The timestamp is captured at the SFD and driven on tuser[PTP_TS_W:1].
// There is no tready: the sink must accept every beat.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | hunting for 0x55 preamble bytes followed by the 0xD5 SFD
// ST_PAYLOAD | frame accepted; bytes flow through the 4-byte FCS delay line
// ST_DROP    | frame rejected; wait for dv to fall
module taxi_axis_gmii_rx #(
  parameter int DATA_W   = 8,
  parameter int PTP_TS_W = 96
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   gmii_rxd,
  input  logic                gmii_rx_dv,
  input  logic                gmii_rx_er,
  output logic [7:0]          m_axis_rx_tdata,
  output logic                m_axis_rx_tvalid,
  output logic                m_axis_rx_tlast,
`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
  output logic [PTP_TS_W:0]   m_axis_rx_tuser,
  input  logic [PTP_TS_W-1:0] ptp_ts,
`else
  output logic [0:0]          m_axis_rx_tuser,
`endif
  input  logic                clk_enable,
  input  logic                mii_select,
  input  logic                cfg_rx_enable,
  output logic                start_packet,
  output logic                error_bad_frame,
  output logic                error_bad_fcs
);

  if (DATA_W != 8) begin : g_data_w_check
    $error("taxi_axis_gmii_rx: only DATA_W = 8 is supported");
  end
  if (PTP_TS_W < 1) begin : g_ptp_w_check
    $error("taxi_axis_gmii_rx: PTP_TS_W must be at least 1");
  end

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rxd_q;
  logic              dv_q, er_q, ce_q, mii_q, cfg_en_q;
  logic [3:0]        nib_prev;
  logic              mii_odd;
  logic [7:0]        rx_byte;
  logic              sfd_nib, byte_en, frame_end;
  logic              take_sfd, push, finish;
  logic [31:0]       crc;
  logic [3:0][7:0]   dly;
  logic [7:0]        hold;
  logic [2:0]        cnt;
  logic              bad_er, frame_bad, crc_bad;

  // CRC-32, reflected form, one byte LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // the residue constant is in MSB-first order, the register is LSB-first
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
  logic [PTP_TS_W-1:0] ptp_reg;

  // timestamp captured with the SFD, held for the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptp_reg <= '0;
    else if (take_sfd) ptp_reg <= ptp_ts;
  end

  function automatic logic [PTP_TS_W:0] make_user(input logic bad);
    return {ptp_reg, bad};
  endfunction
`else
  function automatic logic [0:0] make_user(input logic bad);
    return bad;
  endfunction
`endif

  // single input register stage for all PHY-side and config inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q    <= '0;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      ce_q     <= 1'b0;
      mii_q    <= 1'b0;
      cfg_en_q <= 1'b0;
    end else begin
      rxd_q    <= gmii_rxd;
      dv_q     <= gmii_rx_dv;
      er_q     <= gmii_rx_er;
      ce_q     <= clk_enable;
      mii_q    <= mii_select;
      cfg_en_q <= cfg_rx_enable;
    end
  end

  // byte assembly; in MII a D nibble after a 5 nibble while hunting forces the pair phase
  always_comb begin
    rx_byte   = mii_q ? {rxd_q[3:0], nib_prev} : rxd_q[7:0];
    sfd_nib   = mii_q && (state == ST_IDLE) && (rxd_q[3:0] == 4'hD) && (nib_prev == 4'h5);
    byte_en   = ce_q && dv_q && (!mii_q || mii_odd || sfd_nib);
    frame_end = ce_q && !dv_q;
  end

  // nibble phase tracking; mii_odd set means a low nibble is waiting for its partner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_prev <= 4'h0;
      mii_odd  <= 1'b0;
    end else if (ce_q) begin
      nib_prev <= dv_q ? rxd_q[3:0] : 4'h0;
      mii_odd  <= mii_q && dv_q && !byte_en;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_sfd) state_nxt = ST_PAYLOAD;
        else if (byte_en && rx_byte != 8'h55) state_nxt = ST_DROP;
      end
      ST_PAYLOAD: if (frame_end) state_nxt = ST_IDLE;
      ST_DROP:    if (frame_end) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM action decode
  always_comb begin
    take_sfd  = (state == ST_IDLE) && byte_en && (rx_byte == 8'hD5) && !er_q && cfg_en_q;
    push      = (state == ST_PAYLOAD) && byte_en;
    finish    = (state == ST_PAYLOAD) && frame_end;
    frame_bad = bad_er || mii_odd;
    crc_bad   = rev32(crc) != CRC_RESIDUE;
  end

  // FCS delay line, CRC accumulation and byte count (saturates at 5)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc    <= 32'hFFFFFFFF;
      dly    <= '0;
      hold   <= 8'h00;
      cnt    <= 3'd0;
      bad_er <= 1'b0;
    end else begin
      if (take_sfd) begin
        crc    <= 32'hFFFFFFFF;
        cnt    <= 3'd0;
        bad_er <= 1'b0;
      end else if (push) begin
        dly <= {dly[2:0], rx_byte};
        crc <= crc_byte(crc, rx_byte);
        cnt <= (cnt == 3'd5) ? 3'd5 : cnt + 3'd1;
        if (cnt >= 3'd4) hold <= dly[3];
      end
      if ((state == ST_PAYLOAD) && ce_q && dv_q && er_q) bad_er <= 1'b1;
    end
  end

  // registered stream and status outputs; a beat is held back one byte so tlast can be attached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_rx_tdata  <= 8'h00;
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tlast  <= 1'b0;
      m_axis_rx_tuser  <= '0;
      start_packet     <= 1'b0;
      error_bad_frame  <= 1'b0;
      error_bad_fcs    <= 1'b0;
    end else begin
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tlast  <= 1'b0;
      start_packet     <= take_sfd;
      error_bad_frame  <= 1'b0;
      error_bad_fcs    <= 1'b0;
      if (push && cnt == 3'd5) begin
        m_axis_rx_tvalid <= 1'b1;
        m_axis_rx_tdata  <= hold;
        m_axis_rx_tuser  <= make_user(1'b0);
      end
      if (finish) begin
        m_axis_rx_tvalid <= 1'b1;
        m_axis_rx_tlast  <= 1'b1;
        if (cnt == 3'd5) begin
          m_axis_rx_tdata <= hold;
          m_axis_rx_tuser <= make_user(frame_bad || crc_bad);
          error_bad_frame <= frame_bad;
          error_bad_fcs   <= !frame_bad && crc_bad;
        end else begin
          m_axis_rx_tdata <= 8'h00;
          m_axis_rx_tuser <= make_user(1'b1);
          error_bad_frame <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_taxi_axis_gmii_rx.sv
// Directed bench for taxi_axis_gmii_rx: GMII and MII frames, FCS/rx_er errors,
// short frames, drop on cfg_rx_enable=0, and reset in the middle of a frame.
module tb_taxi_axis_gmii_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  tdata;
  logic        tvalid, tlast;
`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
  logic [96:0] tuser;
  logic [95:0] ptp_ts;
`else
  logic [0:0]  tuser;
`endif
  logic        clk_enable, mii_select, cfg_rx_enable;
  logic        start_packet, error_bad_frame, error_bad_fcs;

  always #5 clk = ~clk;

  taxi_axis_gmii_rx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .gmii_rxd         (gmii_rxd),
    .gmii_rx_dv       (gmii_rx_dv),
    .gmii_rx_er       (gmii_rx_er),
    .m_axis_rx_tdata  (tdata),
    .m_axis_rx_tvalid (tvalid),
    .m_axis_rx_tlast  (tlast),
    .m_axis_rx_tuser  (tuser),
`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
    .ptp_ts           (ptp_ts),
`endif
    .clk_enable       (clk_enable),
    .mii_select       (mii_select),
    .cfg_rx_enable    (cfg_rx_enable),
    .start_packet     (start_packet),
    .error_bad_frame  (error_bad_frame),
    .error_bad_fcs    (error_bad_fcs)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  logic       q_user[$];
  int         q_time[$];
  int n_sp, n_bf, n_fcs, n_ts_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid) begin
        q_data.push_back(tdata);
        q_last.push_back(tlast);
        q_user.push_back(tuser[0]);
        q_time.push_back(cyc);
`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
        if (tuser[96:1] !== 96'h1234) n_ts_bad++;
`endif
      end
      if (start_packet)    n_sp++;
      if (error_bad_frame) n_bf++;
      if (error_bad_fcs)   n_fcs++;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_user.delete();
    q_time.delete();
    n_sp = 0; n_bf = 0; n_fcs = 0; n_ts_bad = 0;
  endtask

  task automatic mii_nibble(input logic [3:0] n, input logic dv, input logic er);
    @(negedge clk);
    gmii_rxd = {4'h0, n}; gmii_rx_dv = dv; gmii_rx_er = er; clk_enable = 1'b1;
    @(negedge clk);
    clk_enable = 1'b0;
  endtask

  // preamble, SFD, payload 0,1,2,..., FCS; optional rx_er / cfg enable / reset at a payload index
  task automatic send_frame(input int n_pay, input logic bad_fcs, input int er_at,
                            input logic mii, input int cfg_on_at, input int rst_at);
    logic [7:0]  fb[$];
    logic [31:0] c;
    logic [7:0]  b;
    logic        er_bit;
    int          p;
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_pay; i++) begin
      b = i[7:0];
      fb.push_back(b);
      for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fb.push_back(c[7:0] ^ {7'h0, bad_fcs});
    fb.push_back(c[15:8]);
    fb.push_back(c[23:16]);
    fb.push_back(c[31:24]);
    for (int idx = 0; idx < fb.size(); idx++) begin
      p = idx - 8;
      if (p == rst_at) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (p == cfg_on_at) cfg_rx_enable = 1'b1;
      er_bit = (p == er_at);
      if (mii) begin
        mii_nibble(fb[idx][3:0], 1'b1, er_bit);
        mii_nibble(fb[idx][7:4], 1'b1, er_bit);
      end else begin
        @(negedge clk);
        gmii_rxd = fb[idx]; gmii_rx_dv = 1'b1; gmii_rx_er = er_bit;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (mii) begin
        mii_nibble(4'h0, 1'b0, 1'b0);
        mii_nibble(4'h0, 1'b0, 1'b0);
      end else begin
        @(negedge clk);
        gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string name, input int n_exp, input logic exp_bad,
                             input int exp_sp, input int exp_bf, input int exp_fcs,
                             input logic exp_last);
    int nlast, nuser;
    nlast = 0; nuser = 0;
    check_eq({name, "_beats"}, q_data.size(), n_exp);
    for (int i = 0; i < q_data.size() && i < n_exp; i++)
      check_eq({name, "_data"}, {24'h0, q_data[i]}, {24'h0, i[7:0]});
    for (int i = 0; i < q_last.size(); i++) begin
      if (q_last[i]) nlast++;
      if (!q_last[i] && q_user[i]) nuser++;
    end
    check_eq({name, "_tlast_count"}, nlast, exp_last ? 1 : 0);
    check_eq({name, "_tuser_midframe"}, nuser, 0);
    if (exp_last && q_data.size() > 0) begin
      check_eq({name, "_tlast_pos"}, {31'h0, q_last[q_last.size()-1]}, 1);
      check_eq({name, "_tuser_last"}, {31'h0, q_user[q_user.size()-1]}, {31'h0, exp_bad});
    end
    check_eq({name, "_start_packet"}, n_sp, exp_sp);
    check_eq({name, "_bad_frame"}, n_bf, exp_bf);
    check_eq({name, "_bad_fcs"}, n_fcs, exp_fcs);
`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
    check_eq({name, "_ptp_ts"}, n_ts_bad, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsp_bad;
    rst_n = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    clk_enable = 1'b1; mii_select = 1'b0; cfg_rx_enable = 1'b1;
`ifdef TAXI_AXIS_GMII_RX_PTP_TS_EN
    ptp_ts = 96'h1234;
`endif
    clear_mon();
    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", {31'h0, tvalid}, 0);
    check_eq("rst_tlast", {31'h0, tlast}, 0);
    check_eq("rst_tuser0", {31'h0, tuser[0]}, 0);
    check_eq("rst_tdata", {24'h0, tdata}, 0);
    check_eq("rst_pulses", {29'h0, start_packet, error_bad_frame, error_bad_fcs}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    clear_mon(); send_frame(60, 1'b0, 9999, 1'b0, 9999, 9999);
    check_frame("gmii_good", 60, 1'b0, 1, 0, 0, 1'b1);

    clear_mon(); send_frame(60, 1'b1, 9999, 1'b0, 9999, 9999);
    check_frame("gmii_bad_fcs", 60, 1'b1, 1, 0, 1, 1'b1);

    clear_mon(); send_frame(60, 1'b0, 10, 1'b0, 9999, 9999);
    check_frame("gmii_rx_er", 60, 1'b1, 1, 1, 0, 1'b1);

    clear_mon(); send_frame(1, 1'b0, 9999, 1'b0, 9999, 9999);
    check_frame("min_frame", 1, 1'b0, 1, 0, 0, 1'b1);

    clear_mon(); send_frame(0, 1'b0, 9999, 1'b0, 9999, 9999);
    check_frame("short_frame", 1, 1'b1, 1, 1, 0, 1'b1);

    mii_select = 1'b1;
    clear_mon(); send_frame(60, 1'b0, 9999, 1'b1, 9999, 9999);
    check_frame("mii_good", 60, 1'b0, 1, 0, 0, 1'b1);
    nsp_bad = 0;
    for (int i = 1; i < q_time.size(); i++)
      if (!q_last[i] && (q_time[i] - q_time[i-1]) != 4) nsp_bad++;
    check_eq("mii_spacing", nsp_bad, 0);
    mii_select = 1'b0; clk_enable = 1'b1;
    repeat (4) @(negedge clk);

    cfg_rx_enable = 1'b0;
    clear_mon(); send_frame(60, 1'b0, 9999, 1'b0, 30, 9999);
    check_frame("cfg_drop", 0, 1'b0, 0, 0, 0, 1'b0);
    clear_mon(); send_frame(60, 1'b0, 9999, 1'b0, 9999, 9999);
    check_frame("after_drop", 60, 1'b0, 1, 0, 0, 1'b1);

    clear_mon(); send_frame(60, 1'b0, 9999, 1'b0, 9999, 20);
    check_frame("rst_abort", 14, 1'b0, 1, 0, 0, 1'b0);
    clear_mon(); send_frame(60, 1'b0, 9999, 1'b0, 9999, 9999);
    check_frame("after_rst", 60, 1'b0, 1, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
